// File: rtl/trees_pkg.sv
// Shared types for the tree object pool and its scheduler.
// Screen coordinates are signed 11-bit values.
package trees_pkg;

  localparam int TREES_DEFAULT = 16;
  localparam int COORD_W = 11;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    SEARCH,
    DEPLOY,
    WAIT_ACK
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, taps 16'hB400.
// Advances on every clock once out of reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      value <= SEED;
    end else if (value[0]) begin
      value <= (value >> 1) ^ 16'hB400;
    end else begin
      value <= value >> 1;
    end
  end

endmodule

// File: rtl/tree_spawn_scheduler.sv
// Periodic round-robin deployment of trees into free pool slots,
// with a pseudo-random spawn X folded into [X_MIN, X_MAX].
module tree_spawn_scheduler
  import trees_pkg::*;
#(
  parameter int          NUMBER_OF_TREES = TREES_DEFAULT,
  parameter int          SPAWN_INTERVAL  = 60,
  parameter int          X_MIN           = 32,
  parameter int          X_MAX           = 607,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          ACK_TIMEOUT     = 8
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       enable,
  input  logic                       startOfFrame,
  input  logic [NUMBER_OF_TREES-1:0] isActive,
  output logic [NUMBER_OF_TREES-1:0] deploy_tree,
  output coord_t                     spawnX,
  output logic                       allSlotsBusy,
  output logic [7:0]                 spawnCount
);

  localparam int IW = $clog2(NUMBER_OF_TREES);
  localparam logic [IW-1:0] LAST = IW'(NUMBER_OF_TREES - 1);
  localparam logic [7:0] FRAME_LAST = 8'(SPAWN_INTERVAL - 1);
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [10:0] XLO = 11'(X_MIN);
  localparam logic [10:0] XHI = 11'(X_MAX);
  localparam logic [10:0] XSPAN = 11'(X_MAX - X_MIN + 1);

  state_t        state, state_n;
  logic [IW-1:0] rr_ptr, scan_idx, slot, scanned;
  logic [7:0]    frame_cnt, ack_cnt;
  logic [15:0]   lfsr;
  logic [10:0]   x_raw, x_fold;
  logic          free, frame_done;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .resetN(resetN),
    .value (lfsr)
  );

  function automatic logic [IW-1:0] wrap_inc(
    input logic [IW-1:0] i
  );
    return (i == LAST) ? '0 : i + IW'(1);
  endfunction

  // Range span is 512..1024, so one subtraction always lands in range.
  always_comb begin
    x_raw = XLO + 11'(lfsr & 16'h03FF);
    x_fold = x_raw;
    if (x_raw > XHI) begin
      x_fold = x_raw - XSPAN;
    end
  end

  always_comb begin
    state_n = state;
    free = !isActive[scan_idx];
    frame_done = startOfFrame &&
                 (frame_cnt == FRAME_LAST);
    unique case (state)
      IDLE: begin
        if (enable) state_n = COUNT;
      end
      COUNT: begin
        if (frame_done) state_n = SEARCH;
      end
      SEARCH: begin
        if (free) begin
          state_n = DEPLOY;
        end else if (scanned == LAST) begin
          state_n = COUNT;
        end
      end
      DEPLOY: begin
        state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (isActive[slot] ||
            ack_cnt == ACK_LAST) begin
          state_n = COUNT;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      scan_idx     <= '0;
      slot         <= '0;
      scanned      <= '0;
      frame_cnt    <= '0;
      ack_cnt      <= '0;
      deploy_tree  <= '0;
      spawnX       <= coord_t'(XLO);
      allSlotsBusy <= 1'b0;
      spawnCount   <= '0;
    end else begin
      state       <= state_n;
      deploy_tree <= '0;
      unique case (state)
        IDLE: begin
          frame_cnt <= '0;
        end
        COUNT: begin
          if (frame_done) begin
            frame_cnt <= '0;
            scan_idx  <= rr_ptr;
            scanned   <= '0;
          end else if (startOfFrame) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        // The pulse is registered here so it is high during DEPLOY.
        SEARCH: begin
          if (state_n == DEPLOY) begin
            slot         <= scan_idx;
            allSlotsBusy <= 1'b0;
            deploy_tree  <= NUMBER_OF_TREES'(1) << scan_idx;
            spawnX       <= coord_t'(x_fold);
            rr_ptr       <= wrap_inc(scan_idx);
            if (spawnCount != 8'hFF) begin
              spawnCount <= spawnCount + 8'd1;
            end
          end else if (!free) begin
            scan_idx <= wrap_inc(scan_idx);
            scanned  <= scanned + IW'(1);
            if (state_n == COUNT) begin
              allSlotsBusy <= 1'b1;
            end
          end
        end
        DEPLOY: begin
          ack_cnt <= '0;
        end
        WAIT_ACK: begin
          ack_cnt <= ack_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
